endec_byte_seq: RTL and testbench

ENDEC_BYTE_SEQ -- requirements
Module: endec_byte_seq

---
 rtl/endec_pkg.sv | 17 +
 rtl/endec_seq_timer.sv | 32 +++
 rtl/endec_byte_seq.sv | 133 +++++++++++++
 tb/tb_endec_byte_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/endec_pkg.sv
// Shared types and constants for the byte-wide nibble-cipher sequencer.
package endec_pkg;

  localparam int NIBBLE_W        = 4;
  localparam int BYTE_W          = 2 * NIBBLE_W;
  localparam int TIMEOUT_DEFAULT = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE_LO,
    ST_WAIT_LO,
    ST_ISSUE_HI,
    ST_WAIT_HI,
    ST_OUT
  } state_e;

endpackage

// File: rtl/endec_seq_timer.sv
// Watchdog for the core wait states: counts enabled cycles and flags expiry on
// the TIMEOUT_CYCLES-th one. Held at zero while clear_i is high.
module endec_seq_timer
  import endec_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired_o = enable_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                      cnt_d = '0;
    else if (enable_i && !expired_o)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/endec_byte_seq.sv
// Splits an accepted byte into two nibbles, runs each through an external
// nibble cipher core, and returns the reassembled byte. Optional core watchdog
// is enabled by defining ENDEC_BYTE_SEQ_TIMEOUT_EN.
module endec_byte_seq
  import endec_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  input  logic [BYTE_W-1:0]   in_data_i,
  output logic                in_ready_o,
  input  logic [NIBBLE_W-1:0] key_i,
  input  logic                mode_i,
  output logic                core_start_o,
  output logic [NIBBLE_W-1:0] core_code_o,
  output logic [NIBBLE_W-1:0] core_key_o,
  output logic                core_mode_o,
  input  logic                core_done_i,
  input  logic [NIBBLE_W-1:0] core_result_i,
  output logic                out_valid_o,
  output logic [BYTE_W-1:0]   out_data_o,
  input  logic                out_ready_i,
  output logic                busy_o,
  output logic                err_o
);

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   byte_q, result_q;
  logic [NIBBLE_W-1:0] key_q;
  logic                mode_q;
  logic                timeout_w;

`ifdef ENDEC_BYTE_SEQ_TIMEOUT_EN
  logic wait_w, expired_w, err_q;

  assign wait_w = (state_q == ST_WAIT_LO) || (state_q == ST_WAIT_HI);

  endec_seq_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (!wait_w || core_done_i),
    .enable_i  (wait_w),
    .expired_o (expired_w)
  );

  // A done arriving on the expiry cycle still wins over the timeout.
  assign timeout_w = expired_w && !core_done_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          err_q <= 1'b0;
    else if (timeout_w) err_q <= 1'b1;
  end
  assign err_o = err_q;
`else
  // Keeps the parameter referenced when the watchdog is compiled out.
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_w = 1'b0;
  assign err_o     = 1'b0;
`endif

  // NOTE: state flops use <= so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (in_valid_i) state_d = ST_ISSUE_LO;
      ST_ISSUE_LO: state_d = ST_WAIT_LO;
      ST_WAIT_LO:  if (core_done_i) state_d = ST_ISSUE_HI;
                   else if (timeout_w) state_d = ST_IDLE;
      ST_ISSUE_HI: state_d = ST_WAIT_HI;
      ST_WAIT_HI:  if (core_done_i) state_d = ST_OUT;
                   else if (timeout_w) state_d = ST_IDLE;
      ST_OUT:      if (out_ready_i) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // NOTE: every output gets a default first, so no path can infer a latch.
  always_comb begin
    in_ready_o   = 1'b0;
    core_start_o = 1'b0;
    core_code_o  = '0;
    out_valid_o  = 1'b0;
    busy_o       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b0;
      end
      ST_ISSUE_LO: begin
        core_start_o = 1'b1;
        core_code_o  = byte_q[NIBBLE_W-1:0];
      end
      ST_WAIT_LO:  core_code_o = byte_q[NIBBLE_W-1:0];
      ST_ISSUE_HI: begin
        core_start_o = 1'b1;
        core_code_o  = byte_q[BYTE_W-1:NIBBLE_W];
      end
      ST_WAIT_HI:  core_code_o = byte_q[BYTE_W-1:NIBBLE_W];
      ST_OUT:      out_valid_o = 1'b1;
      default:     busy_o = 1'b1;
    endcase
  end

  // Operands are latched only on acceptance, so key/mode changes mid-byte are invisible.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_q   <= '0;
      key_q    <= '0;
      mode_q   <= 1'b0;
      result_q <= '0;
    end else begin
      if (state_q == ST_IDLE && in_valid_i) begin
        byte_q <= in_data_i;
        key_q  <= key_i;
        mode_q <= mode_i;
      end
      if (state_q == ST_WAIT_LO && core_done_i) result_q[NIBBLE_W-1:0]      <= core_result_i;
      if (state_q == ST_WAIT_HI && core_done_i) result_q[BYTE_W-1:NIBBLE_W] <= core_result_i;
    end
  end

  assign core_key_o  = key_q;
  assign core_mode_o = mode_q;
  assign out_data_o  = result_q;

endmodule

// File: tb/tb_endec_byte_seq.sv
// Self-checking bench for endec_byte_seq: a behavioural nibble cipher core with
// random latency plus a byte-level reference model of the expected results.
module tb_endec_byte_seq;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       in_valid_i = 1'b0;
  logic [7:0] in_data_i = '0;
  logic       in_ready_o;
  logic [3:0] key_i = '0;
  logic       mode_i = 1'b0;
  logic       core_start_o;
  logic [3:0] core_code_o, core_key_o;
  logic       core_mode_o;
  logic       core_done_i = 1'b0;
  logic [3:0] core_result_i = '0;
  logic       out_valid_o;
  logic [7:0] out_data_o;
  logic       out_ready_i = 1'b0;
  logic       busy_o, err_o;

  int tests_run = 0;
  int tests_failed = 0;

  endec_byte_seq dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .key_i(key_i), .mode_i(mode_i),
    .core_start_o(core_start_o), .core_code_o(core_code_o),
    .core_key_o(core_key_o), .core_mode_o(core_mode_o),
    .core_done_i(core_done_i), .core_result_i(core_result_i),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Nibble cipher: encrypt rotates left by key[1:0] then XORs {key[1:0],2'b00};
  // decrypt undoes both steps.
  function automatic logic [3:0] nib(input logic [3:0] x, input logic [3:0] k, input logic m);
    logic [7:0] t;
    logic [3:0] mask;
    mask = {k[1:0], 2'b00};
    if (!m) begin
      t = {x, x};
      t = t << k[1:0];
      return t[7:4] ^ mask;
    end else begin
      t = {x ^ mask, x ^ mask};
      t = t >> k[1:0];
      return t[3:0];
    end
  endfunction

  function automatic logic [7:0] ref_byte(input logic [7:0] d, input logic [3:0] k, input logic m);
    return {nib(d[7:4], k, m), nib(d[3:0], k, m)};
  endfunction

  // Core model state
  bit         core_en = 1'b1;
  bit         noise_en = 1'b0;
  int         lat_force = 0;
  int         lat_sum = 0;
  int         start_cnt = 0;
  logic [3:0] key_seen[$];
  bit         pend = 1'b0;
  int         cnt = 0;
  logic [3:0] res = '0;

  always @(negedge clk_i) begin
    int lat;
    core_done_i = 1'b0;
    if (rst_i) begin
      pend = 1'b0;
    end else if (pend) begin
      if (cnt == 0) begin
        core_done_i   = 1'b1;
        core_result_i = res;
        pend          = 1'b0;
      end else cnt--;
    end else if (core_start_o) begin
      start_cnt++;
      key_seen.push_back(core_key_o);
      if (core_en) begin
        lat     = (lat_force != 0) ? lat_force : int'($urandom_range(1, 3));
        lat_sum += lat;
        res     = nib(core_code_o, core_key_o, core_mode_o);
        cnt     = lat - 1;
        pend    = 1'b1;
      end
    end else if (noise_en && $urandom_range(0, 3) == 0) begin
      // Stray done pulses outside the wait states must be ignored.
      core_done_i   = 1'b1;
      core_result_i = 4'($urandom);
    end
  end

  task automatic do_byte(input logic [7:0] d, input logic [3:0] k, input logic m,
                         input int hold, input string tag, output logic [7:0] got);
    logic [7:0] exp;
    int         n;
    bit         stable_ok;
    exp = ref_byte(d, k, m);
    got = 'x;
    n = 0;
    @(negedge clk_i);
    while (!in_ready_o && n < 100) begin @(negedge clk_i); n++; end
    tests_run++;
    if (in_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s accept_wait: in_ready_o=%b expected 1", tag, in_ready_o);
      return;
    end
    start_cnt = 0;
    lat_sum   = 0;
    key_seen.delete();
    in_valid_i = 1'b1; in_data_i = d; key_i = k; mode_i = m;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0; key_i = ~k; mode_i = ~m; in_data_i = 8'($urandom);
    n = 0;
    while (!out_valid_o && n < 200) begin @(posedge clk_i); #1; n++; end
    tests_run++;
    if (n !== 2 + lat_sum) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d cycles expected %0d", tag, n, 2 + lat_sum);
    end
    tests_run++;
    if (start_cnt !== 2) begin
      tests_failed++;
      $display("FAIL %s start_pulses: got %0d expected 2", tag, start_cnt);
    end
    tests_run++;
    if (key_seen.size() != 2 || key_seen[0] !== k || key_seen[1] !== k) begin
      tests_failed++;
      $display("FAIL %s core_key: got %p expected two of %h", tag, key_seen, k);
    end
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      in_valid_i = 1'b1; in_data_i = 8'($urandom);
      @(posedge clk_i); #1;
      if (out_valid_o !== 1'b1 || out_data_o !== exp || in_ready_o !== 1'b0) stable_ok = 1'b0;
    end
    tests_run++;
    if (stable_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s hold_stable: output moved during %0d stall cycles (data %h expected %h)",
               tag, hold, out_data_o, exp);
    end
    @(negedge clk_i);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    got = out_data_o;
    tests_run++;
    if (got !== exp || out_valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s data: got %h (valid %b) expected %h", tag, got, out_valid_o, exp);
    end
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    tests_run++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || start_cnt !== 2) begin
      tests_failed++;
      $display("FAIL %s after_handshake: in_ready=%b out_valid=%b starts=%0d expected 1 0 2",
               tag, in_ready_o, out_valid_o, start_cnt);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    tests_run++;
    if ({in_ready_o, core_start_o, core_code_o, core_key_o, core_mode_o,
         out_valid_o, out_data_o, busy_o, err_o} !== {1'b1, 1'b0, 4'h0, 4'h0, 1'b0,
                                                      1'b0, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: rdy=%b st=%b code=%h key=%h mode=%b ov=%b od=%h busy=%b err=%b",
               in_ready_o, core_start_o, core_code_o, core_key_o, core_mode_o,
               out_valid_o, out_data_o, busy_o, err_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_encrypt();
    logic [7:0] got;
    do_byte(8'hA5, 4'h1, 1'b0, 0, "encrypt", got);
    tests_run++;
    if (got !== 8'h1E) begin
      tests_failed++;
      $display("FAIL encrypt_known: got %h expected 1e", got);
    end
  endtask

  task automatic test_decrypt();
    logic [7:0] got;
    do_byte(8'h1E, 4'h1, 1'b1, 0, "decrypt", got);
    tests_run++;
    if (got !== 8'hA5) begin
      tests_failed++;
      $display("FAIL decrypt_known: got %h expected a5", got);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] got;
    do_byte(8'h3C, 4'h6, 1'b0, 10, "backpressure", got);
  endtask

  task automatic test_key_change();
    logic [7:0] got;
    // do_byte flips key_i to ~0x3 = 0xC right after acceptance
    do_byte(8'h5A, 4'h3, 1'b0, 1, "key_change", got);
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    noise_en = 1'b1;
    for (int i = 0; i < 16; i++)
      do_byte(8'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "random", got);
    noise_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int  n;
    bit  seen_out;
    lat_force = 6;
    @(negedge clk_i);
    start_cnt = 0;
    in_valid_i = 1'b1; in_data_i = 8'h77; key_i = 4'h2; mode_i = 1'b0;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    n = 0;
    while (start_cnt < 2 && n < 100) begin @(negedge clk_i); n++; end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    tests_run++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || out_data_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid: busy=%b out_valid=%b in_ready=%b out_data=%h expected 0 0 1 00",
               busy_o, out_valid_o, in_ready_o, out_data_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    lat_force = 0;
    seen_out = 1'b0;
    repeat (30) begin
      @(posedge clk_i); #1;
      if (out_valid_o !== 1'b0 || busy_o !== 1'b0) seen_out = 1'b1;
    end
    tests_run++;
    if (seen_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_discard: activity after reset, out_valid=%b busy=%b", out_valid_o, busy_o);
    end
  endtask

`ifdef ENDEC_BYTE_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bit err_dropped;
    core_en = 1'b0;
    @(negedge clk_i);
    in_valid_i = 1'b1; in_data_i = 8'h99; key_i = 4'h4; mode_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    n = 0;
    while (busy_o && n < 100) begin @(posedge clk_i); #1; n++; end
    tests_run++;
    if (n !== 32 || err_o !== 1'b1 || out_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout: idle after %0d cycles err=%b out_valid=%b expected 32 1 0", n, err_o, out_valid_o);
    end
    err_dropped = 1'b0;
    repeat (10) begin
      @(posedge clk_i); #1;
      if (err_o !== 1'b1) err_dropped = 1'b1;
    end
    tests_run++;
    if (err_dropped !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_sticky: err_o=%b expected 1", err_o);
    end
    core_en = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    tests_run++;
    if (err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_clear: err_o=%b expected 0", err_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_key_change();
    test_back_to_back();
    test_reset_mid();
`ifdef ENDEC_BYTE_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
